// File: rtl/button_sequence_player.sv
// Replays a latched sequence of up to eight P1/P2 presses as fixed-width pulses
// separated by fixed low gaps; done pulses once when the last gap has elapsed.
//
// state | meaning
// IDLE  | waiting for start; a zero-length start only pulses done
// PULSE | driving p1 or p2 for the current press
// GAP   | both lines low between presses; the last gap ends the run
module button_sequence_player #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [3:0] seq_len,
  input  logic [7:0] seq_bits,
  output logic       p1,
  output logic       p2,
  output logic       busy,
  output logic       done
);

  localparam int MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    bits_q, bits_n;
  logic [3:0]    len_q, len_n;
  logic [3:0]    len_clamp;
  logic          done_n;

  // Phase timer is a down-counter loaded on entry; a phase ends at terminal count 0.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    bits_n    = bits_q;
    len_n     = len_q;
    done_n    = 1'b0;
    len_clamp = (seq_len > 4'd8) ? 4'd8 : seq_len;

    case (state)
      IDLE: begin
        if (start) begin
          if (len_clamp != 4'd0) begin
            state_n = PULSE;
            cnt_n   = PULSE_LOAD;
            idx_n   = 3'd0;
            bits_n  = seq_bits;
            len_n   = len_clamp;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_n = GAP;
          cnt_n   = GAP_LOAD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          if ({1'b0, idx} == len_q - 4'd1) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = PULSE;
            cnt_n   = PULSE_LOAD;
            idx_n   = idx + 3'd1;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state view so they line up with the state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= 3'd0;
      bits_q <= 8'd0;
      len_q  <= 4'd0;
      p1     <= 1'b0;
      p2     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      bits_q <= bits_n;
      len_q  <= len_n;
      p1     <= (state_n == PULSE) && !bits_n[idx_n];
      p2     <= (state_n == PULSE) &&  bits_n[idx_n];
      busy   <= (state_n != IDLE);
      done   <= done_n;
    end
  end

endmodule

// File: tb/tb_button_sequence_player.sv
// Randomized bench for button_sequence_player: the stimulus side queues the
// expected press/done events, a monitor pops and checks them as they appear.
module tb_button_sequence_player;

  localparam int P  = 4;
  localparam int G  = 4;
  localparam int PG = P + G;

  logic       clock;
  logic       resetn;
  logic       start;
  logic [3:0] seq_len;
  logic [7:0] seq_bits;
  logic       p1, p2, busy, done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // kind: 0 = P1 press, 1 = P2 press, 2 = done; cyc = sample cycle of the rise
  typedef struct {
    int kind;
    int cyc;
    int busy;
  } exp_t;

  exp_t q[$];

  button_sequence_player #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .start    (start),
    .seq_len  (seq_len),
    .seq_bits (seq_bits),
    .p1       (p1),
    .p2       (p2),
    .busy     (busy),
    .done     (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endfunction

  // Monitor: samples on the falling edge, pops an expectation per observed event.
  initial begin
    logic pp1, pp2;
    int   w1, w2, bc;
    exp_t e;
    pp1 = 1'b0; pp2 = 1'b0; w1 = 0; w2 = 0; bc = 0;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        check(!p1 && !p2 && !busy && !done, "reset_outputs", int'({p1, p2, busy, done}), 0);
        pp1 = 1'b0; pp2 = 1'b0; w1 = 0; w2 = 0; bc = 0;
      end else begin
        check(!(p1 && p2), "p1_p2_exclusive", int'({p1, p2}), 0);
        if (busy) bc++;
        if ((p1 && !pp1) || (p2 && !pp2)) begin
          check(q.size() != 0, "unexpected_press", int'({p1, p2}), 0);
          if (q.size() != 0) begin
            e = q.pop_front();
            check(e.kind == (p2 ? 1 : 0), "press_line", p2 ? 1 : 0, e.kind);
            check(e.cyc == cyc, "press_cycle", cyc, e.cyc);
          end
        end
        if (!p1 && pp1) check(w1 == P, "p1_width", w1, P);
        if (!p2 && pp2) check(w2 == P, "p2_width", w2, P);
        if (done) begin
          check(q.size() != 0, "unexpected_done", 1, 0);
          if (q.size() != 0) begin
            e = q.pop_front();
            check(e.kind == 2, "done_kind", 2, e.kind);
            check(e.cyc == cyc, "done_cycle", cyc, e.cyc);
            check(busy == 1'b0, "busy_at_done", int'(busy), 0);
            check(bc == e.busy, "busy_cycles", bc, e.busy);
          end
          bc = 0;
        end
        w1  = p1 ? w1 + 1 : 0;
        w2  = p2 ? w2 + 1 : 0;
        pp1 = p1;
        pp2 = p2;
      end
    end
  end

  // Issues one start at the current falling edge; during the run the inputs are
  // scrambled to show they are ignored. abort_at > 0 pulses reset at that cycle.
  task automatic run_seq(input int len, input logic [7:0] bits, input int abort_at);
    int L, k;
    exp_t e;
    L        = (len > 8) ? 8 : len;
    start    = 1'b1;
    seq_len  = 4'(len);
    seq_bits = bits;
    k        = cyc + 1;
    for (int n = 0; n < L; n++) begin
      e.kind = int'(bits[n]);
      e.cyc  = k + n * PG;
      e.busy = 0;
      q.push_back(e);
    end
    if (abort_at == 0) begin
      e.kind = 2;
      e.cyc  = k + L * PG;
      e.busy = L * PG;
      q.push_back(e);
    end
    @(negedge clock);
    while (cyc < k + L * PG && !(abort_at > 0 && cyc == k + abort_at)) begin
      start    = 1'($urandom_range(0, 1));
      seq_bits = 8'($urandom);
      seq_len  = 4'($urandom);
      @(negedge clock);
    end
    start = 1'b0;
    if (abort_at > 0) begin
      #2;
      resetn = 1'b0;
      q.delete();
      #1;
      check(!p1 && !p2 && !busy && !done, "abort_outputs", int'({p1, p2, busy, done}), 0);
      start = 1'b1;
      repeat (2) @(negedge clock);
      start  = 1'b0;
      resetn = 1'b1;
      repeat (2) @(negedge clock);
    end
  endtask

  initial begin
    resetn   = 1'b0;
    start    = 1'b1;
    seq_len  = 4'd3;
    seq_bits = 8'h04;
    repeat (5) @(negedge clock);
    start  = 1'b0;
    resetn = 1'b1;
    repeat (3) @(negedge clock);

    run_seq(3, 8'h04, 0);
    run_seq(8, 8'hAA, 0);
    run_seq(15, 8'hAA, 0);
    run_seq(0, 8'h5A, 0);
    repeat (2) @(negedge clock);
    run_seq(3, 8'h04, 9);
    run_seq(3, 8'h04, 0);

    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
      run_seq(int'($urandom_range(0, 15)), 8'($urandom), 0);
    end

    repeat (4) @(negedge clock);
    check(q.size() == 0, "events_outstanding", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
